program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Upstream boot stage for the integrated CPU.
- Receives a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into the dual-port instruction/data memory through a spare write port.
- Holds the CPU in reset until the image checksum verifies, then releases the CPU with start_pc equal to the image entry point.

Parameters:
- ADDR_W, 11, memory word-address width; also the width of start_pc.
- DATA_W, 32, memory word width; must be 32 (4 bytes per word).
- MAGIC, 8'hA5, frame start byte.
- MEM_WORDS, 2048, memory depth in words; equals 2**ADDR_W.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_valid  in  1  byte-stream valid.
- rx_data  in  8  byte-stream payload.
- rx_ready  out  1  loader can accept a byte.
- mem_w_en  out  1  one-cycle memory write strobe.
- mem_addr  out  ADDR_W  memory word address.
- mem_data  out  DATA_W  memory write data.
- cpu_rst_n  out  1  active-low reset driven to the CPU.
- start_pc  out  ADDR_W  entry PC presented to the PC block.
- done  out  1  image loaded and verified; CPU running.
- error  out  1  frame rejected; CPU held in reset.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset rst_n is asynchronous and active-low.
  - Reset values: rx_ready=0, mem_w_en=0, mem_addr=0, mem_data=0, cpu_rst_n=0, start_pc=0, done=0, error=0, state=IDLE.
  - Reset asserted mid-operation aborts immediately. No further writes occur, and the CPU is forced back into reset.
- Handshake:
  - A byte transfers on a clock edge where rx_valid && rx_ready.
  - rx_ready is a registered output. It is 1 in IDLE, HDR, LOAD and CSUM, and 0 in RUN and ERR.
  - rx_data is ignored when no transfer occurs.
- Frame format: MAGIC, base_lo, base_hi, count_lo, count_hi, entry_lo, entry_hi, then count*4 word bytes (LSB first), then csum.
  - Only the low ADDR_W bits of base and entry are used.
  - count is 16 bits.
  - csum is the XOR of every byte after MAGIC, up to and including the last word byte.
- State machine:
  - IDLE:
    - A transferred byte equal to MAGIC clears the checksum accumulator and the byte counter, then goes to HDR.
    - Any other byte is silently discarded.
  - HDR:
    - Captures 6 bytes into base, count and entry, accumulating the checksum.
    - After the 6th byte: if base + count > MEM_WORDS (17-bit compare, no wrap), go to ERR.
    - Otherwise, if count==0, go to CSUM; else go to LOAD with word index 0.
  - LOAD:
    - A 2-bit byte lane counter shifts bytes into a word buffer.
    - On the transfer of lane 3, on the next cycle: mem_w_en=1, mem_addr=base+index (ADDR_W bits), mem_data=assembled word.
    - mem_w_en is high for exactly one cycle per word. Back-to-back words at one byte per cycle are allowed (one write every 4 cycles minimum).
    - After word count-1 is written, go to CSUM.
  - CSUM:
    - On a byte transfer, compare it with the accumulator.
    - Match: go to RUN.
    - Mismatch: go to ERR.
  - RUN:
    - Entered one cycle after the checksum byte transfers.
    - cpu_rst_n=1, done=1, start_pc=entry (stable from RUN entry).
    - Leaves only on rst_n.
  - ERR:
    - error=1, cpu_rst_n=0, done=0.
    - Leaves only on rst_n.
    - Memory contents already written are not rolled back.
- start_pc is loaded from entry on the HDR to LOAD/CSUM transition. It must be stable before cpu_rst_n rises.
- mem_addr and mem_data hold their last values when mem_w_en=0.
- cpu_rst_n and done are never 1 in any state other than RUN.

Decomposition:
- Package loader_pkg:
  - loader_state_t enum {IDLE, HDR, LOAD, CSUM, RUN, ERR}.
  - MAGIC constant, HDR_BYTES=6 constant, frame-field offset constants.
- One natural sub-module: byte_to_word_packer.
  - Holds the lane counter and the shift buffer.
  - Emits word_valid for one cycle with the assembled word.
  - Clears on rst_n and on FSM entry to LOAD.

Test Plan:
1. Frame A5, 10 00, 02 00, 10 00, words 0xE3A01005 and 0xE2811001, correct csum, rx_valid held high -> writes at addr 0x010 then 0x011 with those data. mem_w_en pulses exactly 2 times. cpu_rst_n=1, done=1, start_pc=0x010 one cycle after the csum byte.
2. Same frame with the csum byte XORed with 0x01 -> both writes occur, then error=1, cpu_rst_n stays 0, rx_ready=0, further bytes ignored.
3. Frame with base=0x7FF, count=2 -> ERR after the 6th header byte. No mem_w_en, error=1.
4. Garbage bytes 00 FF 5A before A5, plus rx_valid toggling every other cycle during LOAD -> garbage discarded, same writes as scenario 1, checksum still passes.
5. count=0, entry=0x123 -> after csum byte 0x23^0x01 (base 0) transfers, RUN with start_pc=0x123 and no writes.
6. rst_n pulsed low after the 2nd word byte of scenario 1 -> all outputs return to their reset values immediately. A fresh full frame afterwards loads correctly.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and frame-layout constants for the boot-time program loader.
package loader_pkg;

  typedef enum logic [2:0] {IDLE, HDR, LOAD, CSUM, RUN, ERR} loader_state_t;

  localparam logic [7:0] MAGIC = 8'hA5;
  localparam int HDR_BYTES = 6;

  // Byte offsets of the header fields, counted from the first byte after MAGIC.
  localparam int OFF_BASE_LO  = 0;
  localparam int OFF_BASE_HI  = 1;
  localparam int OFF_COUNT_LO = 2;
  localparam int OFF_COUNT_HI = 3;
  localparam int OFF_ENTRY_LO = 4;
  localparam int OFF_ENTRY_HI = 5;

endpackage

// File: rtl/byte_to_word_packer.sv
// Shifts bytes LSB-first into a word buffer and presents the completed word for one cycle.
module byte_to_word_packer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              lane_last,
  output logic              word_valid,
  output logic [DATA_W-1:0] word_data
);

  localparam int LANES  = DATA_W / 8;
  localparam int LANE_W = $clog2(LANES);

  logic [LANE_W-1:0] lane_reg;
  logic [DATA_W-9:0] shift_reg;
  logic [DATA_W-1:0] shift_next;
  logic [DATA_W-1:0] word_reg;
  logic              word_valid_reg;

  // Newest byte enters at the top so the first byte ends up in bits [7:0].
  assign shift_next = {byte_data, shift_reg};
  assign lane_last  = (lane_reg == LANE_W'(LANES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_reg       <= '0;
      shift_reg      <= '0;
      word_reg       <= '0;
      word_valid_reg <= 1'b0;
    end else begin
      word_valid_reg <= 1'b0;
      if (clr) begin
        lane_reg  <= '0;
        shift_reg <= '0;
      end else if (byte_valid) begin
        lane_reg  <= lane_reg + 1'b1;
        shift_reg <= shift_next[DATA_W-1:8];
        if (lane_last) begin
          word_reg       <= shift_next;
          word_valid_reg <= 1'b1;
        end
      end
    end
  end

  assign word_valid = word_valid_reg;
  assign word_data  = word_reg;

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses a framed byte stream, writes instruction words to memory and
// releases the CPU at the image entry point once the checksum verifies.
module program_loader #(
  parameter int         ADDR_W    = 11,
  parameter int         DATA_W    = 32,
  parameter logic [7:0] MAGIC     = loader_pkg::MAGIC,
  parameter int         MEM_WORDS = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              cpu_rst_n,
  output logic [ADDR_W-1:0] start_pc,
  output logic              done,
  output logic              error
);
  import loader_pkg::*;

  loader_state_t     state_reg, state_next;
  logic [2:0]        hdr_cnt_reg;
  logic [7:0]        hdr_reg [HDR_BYTES-1];
  logic [7:0]        csum_reg;
  logic [15:0]       word_idx_reg;
  logic              rx_ready_reg, cpu_rst_n_reg, done_reg, error_reg;
  logic [ADDR_W-1:0] mem_addr_reg, start_pc_reg;

  logic              xfer, hdr_last, word_last, lane_last, load_entry;
  logic [15:0]       base_full, count_full, entry_full;
  logic [ADDR_W-1:0] base_w;
  logic [16:0]       span;
  logic              unused_hdr_bits;

  assign xfer       = rx_valid && rx_ready_reg;
  assign base_full  = {hdr_reg[OFF_BASE_HI], hdr_reg[OFF_BASE_LO]};
  assign count_full = {hdr_reg[OFF_COUNT_HI], hdr_reg[OFF_COUNT_LO]};
  // entry_hi is the last header byte, so it is taken straight off the bus.
  assign entry_full = {rx_data, hdr_reg[OFF_ENTRY_LO]};
  assign base_w     = base_full[ADDR_W-1:0];
  assign span       = 17'(base_w) + 17'(count_full);
  assign hdr_last   = (hdr_cnt_reg == 3'(OFF_ENTRY_HI));
  assign word_last  = (word_idx_reg == count_full - 16'd1);
  assign load_entry = (state_reg == HDR) && (state_next == LOAD);
  assign unused_hdr_bits = ^{base_full, entry_full};

  for (genvar gi = 0; gi < HDR_BYTES - 1; gi++) begin : g_hdr
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        hdr_reg[gi] <= '0;
      else if (state_reg == HDR && xfer && hdr_cnt_reg == 3'(gi))
        hdr_reg[gi] <= rx_data;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (xfer && rx_data == MAGIC) state_next = HDR;
      HDR: begin
        if (xfer && hdr_last) begin
          if (span > 17'(MEM_WORDS))  state_next = ERR;
          else if (count_full == '0)  state_next = CSUM;
          else                        state_next = LOAD;
        end
      end
      LOAD: if (xfer && lane_last && word_last) state_next = CSUM;
      CSUM: if (xfer) state_next = (rx_data == csum_reg) ? RUN : ERR;
      default: state_next = state_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      hdr_cnt_reg   <= '0;
      csum_reg      <= '0;
      word_idx_reg  <= '0;
      rx_ready_reg  <= 1'b0;
      cpu_rst_n_reg <= 1'b0;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
      mem_addr_reg  <= '0;
      start_pc_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      rx_ready_reg  <= state_next inside {IDLE, HDR, LOAD, CSUM};
      cpu_rst_n_reg <= (state_next == RUN);
      done_reg      <= (state_next == RUN);
      error_reg     <= (state_next == ERR);
      if (state_reg == IDLE && xfer && rx_data == MAGIC) begin
        csum_reg    <= '0;
        hdr_cnt_reg <= '0;
      end
      if (xfer && (state_reg == HDR || state_reg == LOAD))
        csum_reg <= csum_reg ^ rx_data;
      if (state_reg == HDR && xfer) begin
        hdr_cnt_reg <= hdr_cnt_reg + 3'd1;
        if (hdr_last && state_next != ERR) begin
          start_pc_reg <= entry_full[ADDR_W-1:0];
          word_idx_reg <= '0;
        end
      end
      // Address is latched alongside the final lane so it lines up with the packer's strobe.
      if (state_reg == LOAD && xfer && lane_last) begin
        mem_addr_reg <= base_w + word_idx_reg[ADDR_W-1:0];
        word_idx_reg <= word_idx_reg + 16'd1;
      end
    end
  end

  byte_to_word_packer #(.DATA_W(DATA_W)) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (load_entry),
    .byte_valid (xfer && state_reg == LOAD),
    .byte_data  (rx_data),
    .lane_last  (lane_last),
    .word_valid (mem_w_en),
    .word_data  (mem_data)
  );

  assign rx_ready  = rx_ready_reg;
  assign mem_addr  = mem_addr_reg;
  assign cpu_rst_n = cpu_rst_n_reg;
  assign start_pc  = start_pc_reg;
  assign done      = done_reg;
  assign error     = error_reg;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: frame-level reference model, per-cycle compare, directed + random frames.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready, mem_w_en, cpu_rst_n, done, error;
  logic [10:0] mem_addr, start_pc;
  logic [31:0] mem_data;

  program_loader dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_data(mem_data), .cpu_rst_n(cpu_rst_n),
    .start_pc(start_pc), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Frame-level reference model: mode 0 hunting for MAGIC, 1 inside frame, 2 running, 3 rejected.
  int          mode;
  logic [7:0]  fq[$];
  int          m_base, m_cnt;
  logic        exp_ready, exp_wen, exp_run, exp_err;
  logic [10:0] exp_addr, exp_pc;
  logic [31:0] exp_data;

  task automatic model_reset();
    mode = 0; fq.delete(); m_base = 0; m_cnt = 0;
    exp_ready = 0; exp_wen = 0; exp_run = 0; exp_err = 0;
    exp_addr = '0; exp_pc = '0; exp_data = '0;
  endtask

  task automatic model_step(input bit xf, input logic [7:0] b);
    int n;
    logic [7:0] x;
    exp_wen = 0;
    if (xf) begin
      if (mode == 0) begin
        if (b == 8'hA5) begin mode = 1; fq.delete(); end
      end else if (mode == 1) begin
        fq.push_back(b);
        n = fq.size();
        if (n == 6) begin
          m_base = (int'(fq[1]) * 256 + int'(fq[0])) % 2048;
          m_cnt  = int'(fq[3]) * 256 + int'(fq[2]);
          if (m_base + m_cnt > 2048) mode = 3;
          else exp_pc = 11'((int'(fq[5]) * 256 + int'(fq[4])) % 2048);
        end else if (n > 6 && n <= 6 + 4 * m_cnt) begin
          if ((n - 6) % 4 == 0) begin
            exp_wen  = 1;
            exp_addr = 11'((m_base + (n - 6) / 4 - 1) % 2048);
            exp_data = {fq[n-1], fq[n-2], fq[n-3], fq[n-4]};
          end
        end else if (n == 6 + 4 * m_cnt + 1) begin
          x = 0;
          for (int i = 0; i < n - 1; i++) x ^= fq[i];
          mode = (x == b) ? 2 : 3;
        end
      end
    end
    exp_ready = (mode < 2);
    exp_run   = (mode == 2);
    exp_err   = (mode == 3);
  endtask

  logic [10:0] waddr_q[$];
  logic [31:0] wdata_q[$];

  initial model_reset();

  // Single compare process: outputs are stable at negedge; inputs seen here are what the next edge samples.
  always @(negedge clk) begin
    if (!rst_n) model_reset();
    chk("rx_ready",  32'(rx_ready),  32'(exp_ready));
    chk("mem_w_en",  32'(mem_w_en),  32'(exp_wen));
    chk("mem_addr",  32'(mem_addr),  32'(exp_addr));
    chk("mem_data",  mem_data,       exp_data);
    chk("cpu_rst_n", 32'(cpu_rst_n), 32'(exp_run));
    chk("done",      32'(done),      32'(exp_run));
    chk("error",     32'(error),     32'(exp_err));
    chk("start_pc",  32'(start_pc),  32'(exp_pc));
    if (rst_n && mem_w_en) begin waddr_q.push_back(mem_addr); wdata_q.push_back(mem_data); end
    if (rst_n) model_step(rx_valid && exp_ready, rx_data);
  end

  logic [31:0] words[$];
  logic [7:0]  fb[$];

  task automatic build_frame(input logic [15:0] base, input logic [15:0] cnt,
                             input logic [15:0] entry, input logic [7:0] flip);
    logic [7:0] x;
    logic [31:0] w;
    fb.delete();
    fb.push_back(8'hA5);
    fb.push_back(base[7:0]);  fb.push_back(base[15:8]);
    fb.push_back(cnt[7:0]);   fb.push_back(cnt[15:8]);
    fb.push_back(entry[7:0]); fb.push_back(entry[15:8]);
    for (int wi = 0; wi < int'(cnt); wi++) begin
      w = words[wi];
      for (int l = 0; l < 4; l++) fb.push_back(w[8*l +: 8]);
    end
    x = 0;
    for (int i = 1; i < fb.size(); i++) x ^= fb[i];
    fb.push_back(x ^ flip);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got;
    int waited;
    if (gap > 0) begin
      rx_valid = 0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    rx_valid = 1; rx_data = b; got = 0; waited = 0;
    while (!got && waited < 20) begin
      @(negedge clk); got = rx_ready;
      @(posedge clk); #1;
      waited++;
    end
    chk("byte_accept", 32'(got), 32'd1);
  endtask

  task automatic send_frame(input int nbytes, input int gap_mode);
    int g;
    for (int i = 0; i < nbytes; i++) begin
      g = 0;
      if (gap_mode == 1 && i >= 7 && i < fb.size() - 1) g = 1;
      else if (gap_mode == 2) g = $urandom_range(0, 2);
      send_byte(fb[i], g);
    end
    rx_valid = 0;
  endtask

  task automatic do_reset();
    rx_valid = 0; rst_n = 0;
    repeat (3) begin @(posedge clk); #1; end
    waddr_q.delete(); wdata_q.delete();
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic settle();
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic check_scn1(input string tag);
    chk({tag, "_nwrites"}, 32'(waddr_q.size()), 32'd2);
    if (waddr_q.size() == 2) begin
      chk({tag, "_addr0"}, 32'(waddr_q[0]), 32'h010);
      chk({tag, "_data0"}, wdata_q[0], 32'hE3A01005);
      chk({tag, "_addr1"}, 32'(waddr_q[1]), 32'h011);
      chk({tag, "_data1"}, wdata_q[1], 32'hE2811001);
    end
    chk({tag, "_done"},      32'(done),      32'd1);
    chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd1);
    chk({tag, "_start_pc"},  32'(start_pc),  32'h010);
    chk({tag, "_error"},     32'(error),     32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] base, entry;
    int cnt;
    bit ovf;
    logic [7:0] flip;
    bit ok;

    words.delete(); words.push_back(32'hE3A01005); words.push_back(32'hE2811001);

    // Scenario 1: clean two-word frame, back-to-back bytes.
    do_reset();
    chk("reset_rx_ready", 32'(rx_ready), 32'd1);
    build_frame(16'h0010, 16'd2, 16'h0010, 8'h00);
    chk("scn1_csum_byte", 32'(fb[fb.size()-1]), 32'h26);
    send_frame(fb.size(), 0);
    settle();
    check_scn1("scn1");

    // Scenario 2: corrupted checksum; trailing bytes must be ignored.
    do_reset();
    build_frame(16'h0010, 16'd2, 16'h0010, 8'h01);
    send_frame(fb.size(), 0);
    settle();
    chk("scn2_error",     32'(error),     32'd1);
    chk("scn2_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("scn2_rx_ready",  32'(rx_ready),  32'd0);
    rx_valid = 1; rx_data = 8'hA5;
    repeat (4) begin @(posedge clk); #1; end
    rx_valid = 0;
    chk("scn2_nwrites",   32'(waddr_q.size()), 32'd2);
    chk("scn2_error_hold", 32'(error), 32'd1);

    // Scenario 3: base+count exceeds memory.
    do_reset();
    build_frame(16'h07FF, 16'd2, 16'h0000, 8'h00);
    send_frame(7, 0);
    settle();
    chk("scn3_error",   32'(error), 32'd1);
    chk("scn3_done",    32'(done),  32'd0);
    chk("scn3_nwrites", 32'(waddr_q.size()), 32'd0);

    // Scenario 4: leading garbage, rx_valid toggling during LOAD.
    do_reset();
    send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(8'h5A, 0);
    build_frame(16'h0010, 16'd2, 16'h0010, 8'h00);
    send_frame(fb.size(), 1);
    settle();
    check_scn1("scn4");

    // Scenario 5: empty image jumps straight to the checksum.
    do_reset();
    build_frame(16'h0000, 16'd0, 16'h0123, 8'h00);
    chk("scn5_csum_byte", 32'(fb[fb.size()-1]), 32'h22);
    send_frame(fb.size(), 0);
    settle();
    chk("scn5_start_pc", 32'(start_pc), 32'h123);
    chk("scn5_done",     32'(done),     32'd1);
    chk("scn5_nwrites",  32'(waddr_q.size()), 32'd0);

    // Scenario 6: reset mid-load, then a fresh frame.
    do_reset();
    build_frame(16'h0010, 16'd2, 16'h0010, 8'h00);
    send_frame(9, 0);
    rst_n = 0;
    #1;
    chk("scn6_rx_ready",  32'(rx_ready),  32'd0);
    chk("scn6_mem_w_en",  32'(mem_w_en),  32'd0);
    chk("scn6_mem_addr",  32'(mem_addr),  32'd0);
    chk("scn6_mem_data",  mem_data,       32'd0);
    chk("scn6_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("scn6_start_pc",  32'(start_pc),  32'd0);
    chk("scn6_done",      32'(done),      32'd0);
    chk("scn6_error",     32'(error),     32'd0);
    do_reset();
    send_frame(fb.size(), 0);
    settle();
    check_scn1("scn6");

    // Random frames with random gaps, out-of-range headers and corrupted checksums.
    for (int r = 0; r < 10; r++) begin
      do_reset();
      ovf = ($urandom_range(0, 3) == 0);
      cnt = ovf ? $urandom_range(2, 5) : $urandom_range(1, 5);
      base = ovf ? 16'($urandom_range(2049 - cnt, 2047)) : 16'($urandom_range(0, 2048 - cnt));
      base = base | 16'($urandom_range(0, 31) << 11);
      entry = 16'($urandom_range(0, 65535));
      flip = (!ovf && $urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      words.delete();
      for (int wi = 0; wi < cnt; wi++) words.push_back($urandom);
      build_frame(base, 16'(cnt), entry, flip);
      send_frame(ovf ? 7 : fb.size(), 2);
      settle();
      ok = !ovf && (flip == 8'h00);
      chk("rnd_done",    32'(done),  32'(ok));
      chk("rnd_error",   32'(error), 32'(!ok));
      chk("rnd_nwrites", 32'(waddr_q.size()), ovf ? 32'd0 : 32'(cnt));
      if (!ovf) chk("rnd_start_pc", 32'(start_pc), 32'(entry[10:0]));
      if (!ovf && waddr_q.size() > 0) begin
        chk("rnd_addr0", 32'(waddr_q[0]), 32'(base[10:0]));
        chk("rnd_data0", wdata_q[0], words[0]);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
